data_mem_responder: RTL and testbench

//   Data-memory responder: the RAM-side end of the memory-access interface.

---
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder.sv | 107 ++++++++++
 tb/tb_data_mem_responder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Memory-access bus between the memory access unit and the data RAM.
// REQ/ACK handshake with busy and error status.
interface data_mem_responder_if #(
  parameter int AW = 5
);
  logic          REQ;
  logic          RW;
  logic [AW-1:0] ADDR;
  logic [7:0]    DATA_WRITE_TO_RAM;
  logic [7:0]    DATA_READ_FROM_RAM;
  logic          ACK;
  logic          BUSY;
  logic          ERR;

  modport master (
    output REQ, RW, ADDR, DATA_WRITE_TO_RAM,
    input  DATA_READ_FROM_RAM, ACK, BUSY, ERR
  );

  modport slave (
    input  REQ, RW, ADDR, DATA_WRITE_TO_RAM,
    output DATA_READ_FROM_RAM, ACK, BUSY, ERR
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data RAM responder with programmable wait states and REQ/ACK handshake.
// Optional write protection above WP_BASE: define DMEM_WRITE_PROTECT_EN.
module data_mem_responder #(
  parameter int AW          = 5,
  parameter int WAIT_STATES = 1,
  parameter int WP_BASE     = 24
) (
  input logic CLK,
  input logic RST_N,
  data_mem_responder_if.slave bus
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15)
    $error("WAIT_STATES out of range");
  if (WP_BASE < 0)
    $error("WP_BASE must be non-negative");

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [3:0]    cnt;
  logic [AW-1:0] addr_q;
  logic          rw_q;
  logic [7:0]    wdata_q;
  logic [7:0]    rdata_q;
  logic [7:0]    mem [2**AW];

  logic          accept;
  logic          enter_resp;
  logic          blocked;
  logic          wr_en;
  logic [AW-1:0] eff_addr;
  logic          eff_rw;
  logic [7:0]    eff_wdata;

  assign accept     = (state == IDLE) && bus.REQ;
  assign enter_resp = (nxt == RESP) && (state != RESP);

  // With zero wait states RESP is entered on the accept edge itself
  assign eff_addr  = (state == IDLE) ? bus.ADDR : addr_q;
  assign eff_rw    = (state == IDLE) ? bus.RW : rw_q;
  assign eff_wdata = (state == IDLE) ? bus.DATA_WRITE_TO_RAM : wdata_q;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (bus.REQ) nxt = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd0) nxt = RESP;
      RESP: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

`ifdef DMEM_WRITE_PROTECT_EN
  logic err_q;

  assign blocked = eff_rw && (32'(eff_addr) >= WP_BASE);
  assign bus.ERR = (state == RESP) && err_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)          err_q <= 1'b0;
    else if (enter_resp) err_q <= blocked;
  end
`else
  assign blocked = 1'b0;
  assign bus.ERR = 1'b0;
`endif

  // Gate with reset so a held reset can never commit a write
  assign wr_en = RST_N && enter_resp && eff_rw && !blocked;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state <= nxt;
      if (accept) begin
        addr_q  <= bus.ADDR;
        rw_q    <= bus.RW;
        wdata_q <= bus.DATA_WRITE_TO_RAM;
        cnt     <= (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp && !eff_rw) rdata_q <= mem[eff_addr];
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[eff_addr] <= eff_wdata;
  end

  assign bus.ACK                = (state == RESP);
  assign bus.BUSY               = (state != IDLE);
  assign bus.DATA_READ_FROM_RAM = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one-wait-state and
// zero-wait-state instances sharing clock and reset.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  data_mem_responder_if #(.AW(5)) ifa ();
  data_mem_responder_if #(.AW(5)) ifb ();

  data_mem_responder #(.AW(5), .WAIT_STATES(1), .WP_BASE(24)) dut_a (
    .CLK(clk), .RST_N(rst_n), .bus(ifa.slave)
  );

  data_mem_responder #(.AW(5), .WAIT_STATES(0), .WP_BASE(24)) dut_b (
    .CLK(clk), .RST_N(rst_n), .bus(ifb.slave)
  );

  task automatic txn(input bit sel, input bit rw, input logic [4:0] a,
                     input logic [7:0] d, output int lat,
                     output logic [7:0] rd, output logic er);
    lat = 0;
    rd  = 8'hxx;
    er  = 1'bx;
    @(negedge clk);
    if (sel) begin
      ifb.REQ = 1'b1; ifb.RW = rw; ifb.ADDR = a; ifb.DATA_WRITE_TO_RAM = d;
    end else begin
      ifa.REQ = 1'b1; ifa.RW = rw; ifa.ADDR = a; ifa.DATA_WRITE_TO_RAM = d;
    end
    @(posedge clk);
    #1;
    // scramble the don't-care inputs after accept
    if (sel) begin
      ifb.REQ = 1'b0; ifb.RW = ~rw; ifb.ADDR = ~a; ifb.DATA_WRITE_TO_RAM = ~d;
    end else begin
      ifa.REQ = 1'b0; ifa.RW = ~rw; ifa.ADDR = ~a; ifa.DATA_WRITE_TO_RAM = ~d;
    end
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (lat == 0 && (sel ? ifb.ACK : ifa.ACK) === 1'b1) begin
        lat = n;
        rd  = sel ? ifb.DATA_READ_FROM_RAM : ifa.DATA_READ_FROM_RAM;
        er  = sel ? ifb.ERR : ifa.ERR;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (ifa.ACK !== 1'b0) begin
      miscompares++; $display("FAIL reset_ack got %b exp 0", ifa.ACK);
    end
    vectors++;
    if (ifa.BUSY !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy got %b exp 0", ifa.BUSY);
    end
    vectors++;
    if (ifa.ERR !== 1'b0) begin
      miscompares++; $display("FAIL reset_err got %b exp 0", ifa.ERR);
    end
    vectors++;
    if (ifa.DATA_READ_FROM_RAM !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data got %h exp 00", ifa.DATA_READ_FROM_RAM);
    end
    vectors++;
    if (ifb.DATA_READ_FROM_RAM !== 8'h00 || ifb.BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_b got %h/%b exp 00/0",
               ifb.DATA_READ_FROM_RAM, ifb.BUSY);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read;
    int lat; logic [7:0] rd; logic er;
    txn(1'b0, 1'b1, 5'd3, 8'hA5, lat, rd, er);
    vectors++;
    if (lat !== 2) begin
      miscompares++; $display("FAIL wr_latency got %0d exp 2", lat);
    end
    vectors++;
    if (rd !== 8'h00) begin
      miscompares++; $display("FAIL wr_data_held got %h exp 00", rd);
    end
    vectors++;
    if (er !== 1'b0) begin
      miscompares++; $display("FAIL wr_err got %b exp 0", er);
    end
    txn(1'b0, 1'b0, 5'd3, 8'h00, lat, rd, er);
    vectors++;
    if (lat !== 2) begin
      miscompares++; $display("FAIL rd_latency got %0d exp 2", lat);
    end
    vectors++;
    if (rd !== 8'hA5) begin
      miscompares++; $display("FAIL rd_data got %h exp a5", rd);
    end
  endtask

  task automatic test_hold_req;
    int acks = 0;
    int misplaced = 0;
    @(negedge clk);
    ifa.REQ = 1'b1; ifa.RW = 1'b0; ifa.ADDR = 5'd3;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (ifa.ACK === 1'b1) begin
        acks++;
        if (n % 3 != 2) misplaced++;
      end
    end
    ifa.REQ = 1'b0;
    vectors++;
    if (acks !== 3) begin
      miscompares++; $display("FAIL hold_ack_count got %0d exp 3", acks);
    end
    vectors++;
    if (misplaced !== 0) begin
      miscompares++; $display("FAIL hold_ack_spacing got %0d exp 0", misplaced);
    end
    vectors++;
    if (ifa.DATA_READ_FROM_RAM !== 8'hA5) begin
      miscompares++;
      $display("FAIL hold_data got %h exp a5", ifa.DATA_READ_FROM_RAM);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int lat; logic [7:0] rd; logic er;
    int acks = 0;
    txn(1'b0, 1'b1, 5'd5, 8'h11, lat, rd, er);
    vectors++;
    if (lat !== 2) begin
      miscompares++; $display("FAIL abort_pre_latency got %0d exp 2", lat);
    end
    @(negedge clk);
    ifa.REQ = 1'b1; ifa.RW = 1'b1; ifa.ADDR = 5'd5; ifa.DATA_WRITE_TO_RAM = 8'h3C;
    @(posedge clk);
    #1 ifa.REQ = 1'b0;
    @(negedge clk);
    vectors++;
    if (ifa.BUSY !== 1'b1) begin
      miscompares++; $display("FAIL abort_busy_wait got %b exp 1", ifa.BUSY);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (ifa.BUSY !== 1'b0 || ifa.ACK !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_reset got %b/%b exp 0/0", ifa.BUSY, ifa.ACK);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (ifa.ACK === 1'b1) acks++;
    end
    vectors++;
    if (acks !== 0) begin
      miscompares++; $display("FAIL abort_no_ack got %0d exp 0", acks);
    end
    txn(1'b0, 1'b0, 5'd5, 8'h00, lat, rd, er);
    vectors++;
    if (rd !== 8'h11 || lat !== 2) begin
      miscompares++;
      $display("FAIL abort_old_value got %h/%0d exp 11/2", rd, lat);
    end
  endtask

  task automatic test_write_protect;
    int lat; logic [7:0] rd; logic er;
`ifdef DMEM_WRITE_PROTECT_EN
    txn(1'b0, 1'b1, 5'd24, 8'hFF, lat, rd, er);
    vectors++;
    if (er !== 1'b1 || lat !== 2) begin
      miscompares++; $display("FAIL wp_err got %b/%0d exp 1/2", er, lat);
    end
    txn(1'b0, 1'b0, 5'd24, 8'h00, lat, rd, er);
    vectors++;
    if (rd === 8'hFF || er !== 1'b0) begin
      miscompares++; $display("FAIL wp_blocked got %h/%b exp !ff/0", rd, er);
    end
    txn(1'b0, 1'b1, 5'd23, 8'h66, lat, rd, er);
    vectors++;
    if (er !== 1'b0) begin
      miscompares++; $display("FAIL wp_below_err got %b exp 0", er);
    end
    txn(1'b0, 1'b0, 5'd23, 8'h00, lat, rd, er);
    vectors++;
    if (rd !== 8'h66) begin
      miscompares++; $display("FAIL wp_below_data got %h exp 66", rd);
    end
`else
    txn(1'b0, 1'b1, 5'd24, 8'hFF, lat, rd, er);
    vectors++;
    if (er !== 1'b0) begin
      miscompares++; $display("FAIL nowp_err got %b exp 0", er);
    end
    txn(1'b0, 1'b0, 5'd24, 8'h00, lat, rd, er);
    vectors++;
    if (rd !== 8'hFF) begin
      miscompares++; $display("FAIL nowp_data got %h exp ff", rd);
    end
`endif
  endtask

  task automatic test_zero_wait;
    int lat; logic [7:0] rd; logic er;
    txn(1'b1, 1'b1, 5'd31, 8'h5A, lat, rd, er);
    vectors++;
    if (lat !== 1 || rd !== 8'h00) begin
      miscompares++; $display("FAIL zw_write got %0d/%h exp 1/00", lat, rd);
    end
    txn(1'b1, 1'b0, 5'd31, 8'h00, lat, rd, er);
    vectors++;
    if (lat !== 1 || rd !== 8'h5A) begin
      miscompares++; $display("FAIL zw_read got %0d/%h exp 1/5a", lat, rd);
    end
    txn(1'b1, 1'b1, 5'd30, 8'h77, lat, rd, er);
    vectors++;
    if (rd !== 8'h5A) begin
      miscompares++; $display("FAIL zw_data_held got %h exp 5a", rd);
    end
    txn(1'b1, 1'b0, 5'd30, 8'h00, lat, rd, er);
    vectors++;
    if (rd !== 8'h77) begin
      miscompares++; $display("FAIL zw_read2 got %h exp 77", rd);
    end
  endtask

  initial begin
    ifa.REQ = 1'b0; ifa.RW = 1'b0; ifa.ADDR = '0; ifa.DATA_WRITE_TO_RAM = '0;
    ifb.REQ = 1'b0; ifb.RW = 1'b0; ifb.ADDR = '0; ifb.DATA_WRITE_TO_RAM = '0;
    test_reset();
    test_write_read();
    test_hold_req();
    test_reset_abort();
    test_write_protect();
    test_zero_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
